// File: rtl/frv_ex_dispatch.sv
// Operand dispatch between decode and the execute-stage ALU: bypass resolution, immediate select,
// producer interlock and a 2-entry registered buffer feeding execute over valid/ready.
module frv_ex_dispatch #(
    parameter int XLEN = 32,
    parameter int OPW  = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [4:0]      s_rd,
    input  logic            s_rd_wen,
    input  logic [4:0]      s_rs1,
    input  logic [4:0]      s_rs2,
    input  logic [XLEN-1:0] s_rs1_data,
    input  logic [XLEN-1:0] s_rs2_data,
    input  logic [XLEN-1:0] s_imm,
    input  logic            s_use_imm,
    input  logic [OPW-1:0]  s_op,
    input  logic            fwd_ex_valid,
    input  logic            fwd_wb_valid,
    input  logic            fwd_ex_rdy,
    input  logic            fwd_wb_rdy,
    input  logic [4:0]      fwd_ex_rd,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_ex_data,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [XLEN-1:0] m_opr_a,
    output logic [XLEN-1:0] m_opr_b,
    output logic [4:0]      m_shamt,
    output logic [OPW-1:0]  m_op,
    output logic [4:0]      m_rd,
    output logic            m_rd_wen
);
    localparam int XL = XLEN - 1;

    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;

    logic [XL:0]    ent_a_q   [2];
    logic [XL:0]    ent_b_q   [2];
    logic [OPW-1:0] ent_op_q  [2];
    logic [4:0]     ent_rd_q  [2];
    logic           ent_wen_q [2];

    logic [XL:0]    m_opr_a_q, m_opr_b_q;
    logic [OPW-1:0] m_op_q;
    logic [4:0]     m_rd_q;
    logic           m_rd_wen_q;

    logic ex_hit1, ex_hit2, wb_hit1, wb_hit2;
    logic fwd_haz1, fwd_haz2, buf_haz1, buf_haz2, hazard;
    logic ent_vld0, ent_vld1;
    logic accept, pop, head_new;
    logic [XL:0] res_rs1, res_rs2, opr_a, opr_b;

    assign ex_hit1 = fwd_ex_valid && (fwd_ex_rd == s_rs1);
    assign ex_hit2 = fwd_ex_valid && (fwd_ex_rd == s_rs2);
    assign wb_hit1 = fwd_wb_valid && (fwd_wb_rd == s_rs1);
    assign wb_hit2 = fwd_wb_valid && (fwd_wb_rd == s_rs2);

    assign res_rs1 = (s_rs1 == 5'd0) ? '0 :
                     ex_hit1 ? fwd_ex_data :
                     wb_hit1 ? fwd_wb_data : s_rs1_data;
    assign res_rs2 = (s_rs2 == 5'd0) ? '0 :
                     ex_hit2 ? fwd_ex_data :
                     wb_hit2 ? fwd_wb_data : s_rs2_data;

    assign opr_a = res_rs1;
    assign opr_b = s_use_imm ? s_imm : res_rs2;

    // An execute-stage match shadows any writeback match for the same source.
    assign fwd_haz1 = ex_hit1 ? !fwd_ex_rdy : (wb_hit1 && !fwd_wb_rdy);
    assign fwd_haz2 = ex_hit2 ? !fwd_ex_rdy : (wb_hit2 && !fwd_wb_rdy);

    assign ent_vld0 = (count_q == 2'd2) || ((count_q == 2'd1) && !rd_ptr_q);
    assign ent_vld1 = (count_q == 2'd2) || ((count_q == 2'd1) &&  rd_ptr_q);

    assign buf_haz1 = (s_rs1 != 5'd0) &&
                      ((ent_vld0 && ent_wen_q[0] && (ent_rd_q[0] == s_rs1)) ||
                       (ent_vld1 && ent_wen_q[1] && (ent_rd_q[1] == s_rs1)));
    assign buf_haz2 = (s_rs2 != 5'd0) &&
                      ((ent_vld0 && ent_wen_q[0] && (ent_rd_q[0] == s_rs2)) ||
                       (ent_vld1 && ent_wen_q[1] && (ent_rd_q[1] == s_rs2)));

    assign hazard  = fwd_haz1 || buf_haz1 || (!s_use_imm && (fwd_haz2 || buf_haz2));
    assign s_ready = g_resetn && !flush && (count_q != 2'd2) && !hazard;
    assign m_valid = (count_q != 2'd0);
    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (accept) wr_ptr_d = ~wr_ptr_q;
            if (pop)    rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, accept} - {1'b0, pop};
        end
    end

    // The new head is the incoming instruction when it lands in the slot the read pointer moves to.
    assign head_new = accept && (rd_ptr_d == wr_ptr_q);

    always_ff @(posedge g_clk) begin
        if (accept) begin
            ent_a_q[wr_ptr_q]   <= opr_a;
            ent_b_q[wr_ptr_q]   <= opr_b;
            ent_op_q[wr_ptr_q]  <= s_op;
            ent_rd_q[wr_ptr_q]  <= s_rd;
            ent_wen_q[wr_ptr_q] <= s_rd_wen;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            m_opr_a_q  <= '0;
            m_opr_b_q  <= '0;
            m_op_q     <= '0;
            m_rd_q     <= '0;
            m_rd_wen_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (count_d != 2'd0) begin
                m_opr_a_q  <= head_new ? opr_a    : ent_a_q[rd_ptr_d];
                m_opr_b_q  <= head_new ? opr_b    : ent_b_q[rd_ptr_d];
                m_op_q     <= head_new ? s_op     : ent_op_q[rd_ptr_d];
                m_rd_q     <= head_new ? s_rd     : ent_rd_q[rd_ptr_d];
                m_rd_wen_q <= head_new ? s_rd_wen : ent_wen_q[rd_ptr_d];
            end
        end
    end

    assign m_opr_a  = m_opr_a_q;
    assign m_opr_b  = m_opr_b_q;
    assign m_shamt  = m_opr_b_q[4:0];
    assign m_op     = m_op_q;
    assign m_rd     = m_rd_q;
    assign m_rd_wen = m_rd_wen_q;

endmodule
